// File: rtl/cordic_pkg.sv
// Purpose: shared constants, types and helpers for the CORDIC phase path
//          (phase generator, rotator, downstream restore stage).
// Contents: phase width/constants (degrees x10000), quadrant encoding,
//           folded-sample payload struct, modulo-360 add helper.
package cordic_pkg;

  localparam int unsigned PHASE_W    = 22;
  localparam int unsigned SUM_W      = PHASE_W + 1;
  localparam int unsigned PHASE_FULL = 3_600_000;
  localparam int unsigned Q90        = 900_000;
  localparam int unsigned Q180       = 1_800_000;
  localparam int unsigned Q270       = 2_700_000;

  typedef logic [PHASE_W-1:0] phase_t;

  // Source quadrant carried alongside the rotator pipeline.
  // Restore convention: Q2: cos=-sin_pre, sin=cos_pre
  //                     Q3: cos=-cos_pre, sin=-sin_pre
  //                     Q4: cos= sin_pre, sin=-cos_pre
  typedef enum logic [1:0] {
    QUAD_1 = 2'd0,
    QUAD_2 = 2'd1,
    QUAD_3 = 2'd2,
    QUAD_4 = 2'd3
  } quadrant_t;

  typedef struct packed {
    logic signed [PHASE_W-1:0] phase_pre;
    quadrant_t                 quadrant;
  } fold_t;

  // a + b modulo one turn; both operands must already be in [0, PHASE_FULL).
  function automatic phase_t phase_wrap_add(input phase_t a, input phase_t b);
    logic [SUM_W-1:0] s;
    phase_t           r;
    s = SUM_W'(a) + SUM_W'(b);
    if (s >= SUM_W'(PHASE_FULL)) r = PHASE_W'(s - SUM_W'(PHASE_FULL));
    else                         r = PHASE_W'(s);
    return r;
  endfunction

endpackage

// File: rtl/cordic_phase_gen_if.sv
// Purpose: control/sample bus of the phase generator.
// Signals: enable, freq_word, freq_load, phase_offset, sync_clr (to generator);
//          phase_pre, quadrant_flag, out_valid, step_err (from generator).
// Modports: master = controller side, slave = cordic_phase_gen.
interface cordic_phase_gen_if;
  import cordic_pkg::*;

  logic                      enable;
  phase_t                    freq_word;
  logic                      freq_load;
  phase_t                    phase_offset;
  logic                      sync_clr;
  logic signed [PHASE_W-1:0] phase_pre;
  logic [1:0]                quadrant_flag;
  logic                      out_valid;
  logic                      step_err;

  modport master (
    output enable, freq_word, freq_load, phase_offset, sync_clr,
    input  phase_pre, quadrant_flag, out_valid, step_err
  );

  modport slave (
    input  enable, freq_word, freq_load, phase_offset, sync_clr,
    output phase_pre, quadrant_flag, out_valid, step_err
  );

endinterface

// File: rtl/cordic_quadrant_fold.sv
// Purpose: combinational fold of a phase in [0, PHASE_FULL) into the first
//          quadrant using compares and subtracts only.
// Ports: ph_i (phase in), phase_pre_c_o (phase minus q*Q90), quad_c_o (q).
module cordic_quadrant_fold
  import cordic_pkg::*;
(
  input  phase_t                    ph_i,
  output logic signed [PHASE_W-1:0] phase_pre_c_o,
  output quadrant_t                 quad_c_o
);

  always_comb begin
    quad_c_o      = QUAD_1;
    phase_pre_c_o = signed'(ph_i);
    if (ph_i >= PHASE_W'(Q270)) begin
      quad_c_o      = QUAD_4;
      phase_pre_c_o = signed'(PHASE_W'(ph_i - PHASE_W'(Q270)));
    end else if (ph_i >= PHASE_W'(Q180)) begin
      quad_c_o      = QUAD_3;
      phase_pre_c_o = signed'(PHASE_W'(ph_i - PHASE_W'(Q180)));
    end else if (ph_i >= PHASE_W'(Q90)) begin
      quad_c_o      = QUAD_2;
      phase_pre_c_o = signed'(PHASE_W'(ph_i - PHASE_W'(Q90)));
    end
  end

endmodule

// File: rtl/cordic_phase_gen.sv
// Purpose: phase generator for the CORDIC rotator. Modulo-360 accumulator
//          (stage A), static offset add (stage B), quadrant fold (stage C).
//          Two-cycle latency from the enable edge, one sample per cycle.
// Ports: clk, aresetn (async, active-low),
//        phase_if (slave): enable/freq_word/freq_load/phase_offset/sync_clr in,
//        phase_pre/quadrant_flag/out_valid/step_err out (all registered).
module cordic_phase_gen
  import cordic_pkg::*;
(
  input  logic               clk,
  input  logic               aresetn,
  cordic_phase_gen_if.slave  phase_if
);

  phase_t    step_q, step_d;
  logic      step_err_q, step_err_d;
  phase_t    acc_q, acc_d;
  logic      v_a_q, v_a_d;
  phase_t    ph_q, ph_d;
  logic      v_b_q, v_b_d;
  fold_t     out_q, out_d;
  logic      out_valid_q, out_valid_d;

  phase_t                    off_c;
  logic signed [PHASE_W-1:0] fold_pre_c;
  quadrant_t                 fold_quad_c;

  // Out-of-range offsets are treated as zero so the sum stays one subtract.
  assign off_c = (phase_if.phase_offset >= PHASE_W'(PHASE_FULL)) ? '0
                                                                 : phase_if.phase_offset;

  cordic_quadrant_fold u_fold (
    .ph_i          (ph_q),
    .phase_pre_c_o (fold_pre_c),
    .quad_c_o      (fold_quad_c)
  );

  // Next-state logic for step register and the three pipeline stages.
  always_comb begin
    step_d      = step_q;
    step_err_d  = 1'b0;
    acc_d       = acc_q;
    v_a_d       = phase_if.enable;
    ph_d        = ph_q;
    v_b_d       = v_a_q;
    out_d       = out_q;
    out_valid_d = v_b_q;

    if (phase_if.freq_load) begin
      if (phase_if.freq_word < PHASE_W'(PHASE_FULL)) step_d     = phase_if.freq_word;
      else                                            step_err_d = 1'b1;
    end

    // Accumulate uses the step held before this edge, so a same-cycle load
    // only takes effect on the following enabled cycle.
    if (phase_if.sync_clr)    acc_d = '0;
    else if (phase_if.enable) acc_d = phase_wrap_add(acc_q, step_q);

    if (v_a_q) ph_d = phase_wrap_add(acc_q, off_c);

    if (v_b_q) begin
      out_d.phase_pre = fold_pre_c;
      out_d.quadrant  = fold_quad_c;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      step_q      <= '0;
      step_err_q  <= 1'b0;
      acc_q       <= '0;
      v_a_q       <= 1'b0;
      ph_q        <= '0;
      v_b_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      step_q      <= step_d;
      step_err_q  <= step_err_d;
      acc_q       <= acc_d;
      v_a_q       <= v_a_d;
      ph_q        <= ph_d;
      v_b_q       <= v_b_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign phase_if.phase_pre     = out_q.phase_pre;
  assign phase_if.quadrant_flag = out_q.quadrant;
  assign phase_if.out_valid     = out_valid_q;
  assign phase_if.step_err      = step_err_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Purpose: self-checking bench for cordic_phase_gen; directed scenarios plus
//          randomized traffic against an arithmetic (mod/div) reference model.
module tb_cordic_phase_gen;

  localparam int PF  = 3_600_000;
  localparam int Q90 = 900_000;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  cordic_phase_gen_if pg ();

  cordic_phase_gen dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .phase_if (pg)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: accumulator in degrees x10000 plus the samples
  // in flight, and the outputs expected after the current edge.
  int m_step, m_acc;
  bit a_v;  int a_acc;
  bit b_v;  int b_ph;
  bit e_v;  int e_pre, e_q;
  bit e_err;

  int seen_pre[$];
  int seen_q[$];

  task automatic check_val(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_step = 0; m_acc = 0;
    a_v = 0; a_acc = 0;
    b_v = 0; b_ph = 0;
    e_v = 0; e_pre = 0; e_q = 0; e_err = 0;
  endtask

  function automatic int seen_at(input int idx, input bit want_q);
    if (idx >= seen_pre.size()) return -1;
    return want_q ? seen_q[idx] : seen_pre[idx];
  endfunction

  task automatic check_seen(input string tag, input int idx, input int pre, input int q);
    check_val({tag, "_pre"}, seen_at(idx, 1'b0), pre);
    check_val({tag, "_q"},   seen_at(idx, 1'b1), q);
  endtask

  // One clock cycle: drive inputs, advance the model, compare all outputs.
  task automatic cyc(input bit en, input bit ld, input int fw, input int off, input bit clr);
    @(negedge clk);
    pg.enable       = en;
    pg.freq_load    = ld;
    pg.freq_word    = 22'(fw);
    pg.phase_offset = 22'(off);
    pg.sync_clr     = clr;
    @(posedge clk);
    e_v = b_v;
    if (b_v) begin
      e_pre = b_ph % Q90;
      e_q   = b_ph / Q90;
    end
    b_v = a_v;
    if (a_v) b_ph = (a_acc + ((off >= PF) ? 0 : off)) % PF;
    a_v = en;
    if (clr)     m_acc = 0;
    else if (en) m_acc = (m_acc + m_step) % PF;
    a_acc = m_acc;
    e_err = ld && (fw >= PF);
    if (ld && fw < PF) m_step = fw;
    #1;
    check_val("out_valid",     int'(pg.out_valid),     int'(e_v));
    check_val("step_err",      int'(pg.step_err),      int'(e_err));
    check_val("phase_pre",     int'(pg.phase_pre),     e_pre);
    check_val("quadrant_flag", int'(pg.quadrant_flag), e_q);
    if (pg.out_valid) begin
      seen_pre.push_back(int'(pg.phase_pre));
      seen_q.push_back(int'(pg.quadrant_flag));
    end
  endtask

  task automatic run_en(input int n, input int off);
    repeat (n) cyc(1'b1, 1'b0, 0, off, 1'b0);
  endtask

  task automatic flush(input int off);
    repeat (2) cyc(1'b0, 1'b0, 0, off, 1'b0);
  endtask

  task automatic clear_seen();
    seen_pre.delete();
    seen_q.delete();
  endtask

  initial begin
    pg.enable = 1'b0; pg.freq_load = 1'b0; pg.freq_word = '0;
    pg.phase_offset = '0; pg.sync_clr = 1'b0;
    model_reset();

    // Reset state.
    #3;
    check_val("rst_valid", int'(pg.out_valid), 0);
    check_val("rst_pre",   int'(pg.phase_pre), 0);
    #9 aresetn = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 0, 0, 1'b0);

    // Sweep with step 300000.
    cyc(1'b0, 1'b1, 300_000, 0, 1'b1);
    clear_seen();
    run_en(13, 0);
    flush(0);
    check_val("sweep_count", seen_pre.size(), 13);
    check_seen("sweep0",  0,  300_000, 0);
    check_seen("sweep1",  1,  600_000, 0);
    check_seen("sweep2",  2,  0,       1);
    check_seen("sweep8",  8,  0,       3);
    check_seen("sweep11", 11, 0,       0);

    // Mid-stream asynchronous reset.
    run_en(3, 0);
    @(posedge clk); #3;
    aresetn = 1'b0;
    #1;
    check_val("mrst_valid", int'(pg.out_valid),     0);
    check_val("mrst_pre",   int'(pg.phase_pre),     0);
    check_val("mrst_q",     int'(pg.quadrant_flag), 0);
    check_val("mrst_err",   int'(pg.step_err),      0);
    model_reset();
    @(negedge clk);
    pg.enable = 1'b0;
    aresetn   = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 0, 0, 1'b0);

    // Wrap boundary with maximal step.
    cyc(1'b0, 1'b1, 3_599_999, 0, 1'b1);
    clear_seen();
    run_en(2, 0);
    flush(0);
    check_seen("wrap0", 0, 899_999, 3);
    check_seen("wrap1", 1, 899_998, 3);

    // Offset wrap and out-of-range offset.
    cyc(1'b0, 1'b1, 300_000, 1_000_000, 1'b1);
    clear_seen();
    run_en(10, 1_000_000);
    flush(1_000_000);
    check_seen("off_wrap", 9, 400_000, 0);
    cyc(1'b0, 1'b0, 0, 3_600_000, 1'b1);
    clear_seen();
    run_en(1, 3_600_000);
    flush(3_600_000);
    check_seen("off_ill", 0, 300_000, 0);

    // Illegal load, then load together with enable.
    cyc(1'b0, 1'b1, 3_600_000, 0, 1'b0);
    check_val("err_pulse", int'(pg.step_err), 1);
    cyc(1'b0, 1'b0, 0, 0, 1'b1);
    check_val("err_once", int'(pg.step_err), 0);
    clear_seen();
    cyc(1'b1, 1'b1, 100_000, 0, 1'b0);
    run_en(1, 0);
    flush(0);
    check_seen("ld_en0", 0, 300_000, 0);
    check_seen("ld_en1", 1, 400_000, 0);

    // sync_clr together with enable.
    clear_seen();
    cyc(1'b1, 1'b0, 0, 1_800_000, 1'b1);
    run_en(1, 1_800_000);
    flush(1_800_000);
    check_seen("clr_en0", 0, 0,       2);
    check_seen("clr_en1", 1, 100_000, 2);

    // Randomized traffic.
    begin
      int off;
      off = 0;
      for (int i = 0; i < 400; i++) begin
        bit en, ld, clr;
        int fw;
        en  = ($urandom_range(3) != 0);
        ld  = ($urandom_range(15) == 0);
        clr = ($urandom_range(31) == 0);
        if ($urandom_range(7) == 0) fw = PF + int'($urandom_range(4_194_303 - PF));
        else                        fw = int'($urandom_range(PF - 1));
        if ($urandom_range(7) == 0) begin
          if ($urandom_range(9) == 0) off = PF + int'($urandom_range(4_194_303 - PF));
          else                        off = int'($urandom_range(PF - 1));
        end
        cyc(en, ld, fw, off, clr);
      end
      flush(off);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
